// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gating controller.
// Optional feature macro: CLOCK_GATE_CTRL_STATS_EN (per-domain gated-cycle counters).
package cgc_pkg;

  // Per-domain controller state, also exported on domain_state.
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    GATED = 2'b10,
    WAKE  = 2'b11
  } cgc_state_e;

  // Width of each gated-cycle statistics counter.
  localparam int CGC_STAT_W = 32;

  // Counter width large enough to hold the larger of the idle and wake windows.
  function automatic int cgc_cnt_w(input int idle_cycles, input int wake_cycles);
    int m;
    m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Handshake bundle between the clock-gating controller and the gated domains.
// Optional feature macro: CLOCK_GATE_CTRL_STATS_EN adds gated_cycles.
//
// Handshake: quiesce_req is a level request from the controller; the domain
// answers with quiesce_ack (sampled only while that domain is draining).
// quiesce_req stays high until the domain is fully running again, and
// domain_ready is high only while the domain clock runs and is stable.
interface clock_gate_ctrl_if
  import cgc_pkg::*;
#(
  parameter int N_DOMAINS = 4
);
  logic                   global_enable;
  logic [N_DOMAINS-1:0]   force_on;
  logic [N_DOMAINS-1:0]   busy;
  logic [N_DOMAINS-1:0]   wake_req;
  logic [N_DOMAINS-1:0]   quiesce_ack;
  logic [N_DOMAINS-1:0]   quiesce_req;
  logic [N_DOMAINS-1:0]   gate_en;
  logic [N_DOMAINS-1:0]   domain_ready;
  logic [2*N_DOMAINS-1:0] domain_state;
`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [CGC_STAT_W*N_DOMAINS-1:0] gated_cycles;

  modport master (
    input  global_enable, force_on, busy, wake_req, quiesce_ack,
    output quiesce_req, gate_en, domain_ready, domain_state, gated_cycles
  );
  modport slave (
    output global_enable, force_on, busy, wake_req, quiesce_ack,
    input  quiesce_req, gate_en, domain_ready, domain_state, gated_cycles
  );
`else
  modport master (
    input  global_enable, force_on, busy, wake_req, quiesce_ack,
    output quiesce_req, gate_en, domain_ready, domain_state
  );
  modport slave (
    output global_enable, force_on, busy, wake_req, quiesce_ack,
    input  quiesce_req, gate_en, domain_ready, domain_state
  );
`endif
endinterface

// File: rtl/clock_gate_ctrl_domain_fsm.sv
// One domain's gating FSM: idle window, quiesce handshake, gate, timed wake.
// All outputs are flops on the ungated clock so gate_en only moves on a
// rising edge while the ClockGate latch is opaque.
// Optional feature macro: CLOCK_GATE_CTRL_STATS_EN adds the gated-cycle counter.
module cgc_domain_fsm
  import cgc_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  global_enable,
  input  logic                  force_on,
  input  logic                  busy,
  input  logic                  wake_req,
  input  logic                  quiesce_ack,
  output logic                  quiesce_req,
  output logic                  gate_en,
  output logic                  domain_ready,
`ifdef CLOCK_GATE_CTRL_STATS_EN
  output logic [CGC_STAT_W-1:0] gated_cycles,
`endif
  output cgc_state_e            domain_state
);

  localparam int CNT_W = cgc_cnt_w(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  cgc_state_e       state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic             qreq_q, qreq_d;
  logic             gate_q, gate_d;
  logic             ready_q, ready_d;

  logic idle;
  logic hold;

  // Reasons to keep or bring the clock running, and the pure-idle condition.
  always_comb begin
    hold = wake_req | force_on | ~global_enable;
    idle = ~busy & ~hold;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    qreq_d     = qreq_q;
    gate_d     = gate_q;
    ready_d    = ready_q;
    case (state_q)
      RUN: begin
        if (idle) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = DRAIN;
            idle_cnt_d = '0;
            qreq_d     = 1'b1;
            ready_d    = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      DRAIN: begin
        // New work or a hold reason wins over a same-cycle acknowledge.
        if (busy | hold) begin
          state_d    = RUN;
          idle_cnt_d = '0;
          qreq_d     = 1'b0;
          ready_d    = 1'b1;
        end else if (quiesce_ack) begin
          state_d = GATED;
          gate_d  = 1'b0;
        end
      end
      GATED: begin
        // busy is meaningless here: the domain has no clock.
        if (hold) begin
          state_d    = WAKE;
          gate_d     = 1'b1;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // The wake always completes; inputs cannot abort it.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = '0;
          qreq_d     = 1'b0;
          ready_d    = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = '0;
        qreq_d     = 1'b0;
        gate_d     = 1'b1;
        ready_d    = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs; reset leaves the clock running.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      qreq_q     <= 1'b0;
      gate_q     <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      qreq_q     <= qreq_d;
      gate_q     <= gate_d;
      ready_q    <= ready_d;
    end
  end

  assign quiesce_req  = qreq_q;
  assign gate_en      = gate_q;
  assign domain_ready = ready_q;
  assign domain_state = state_q;

`ifdef CLOCK_GATE_CTRL_STATS_EN
  logic [CGC_STAT_W-1:0] gated_cnt_q, gated_cnt_d;

  // Saturating count of cycles spent gated.
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if ((state_q == GATED) && (gated_cnt_q != {CGC_STAT_W{1'b1}})) begin
      gated_cnt_d = gated_cnt_q + CGC_STAT_W'(1);
    end
  end

  // Statistics register, cleared only by reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gated_cnt_q <= '0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign gated_cycles = gated_cnt_q;
`endif

endmodule

// File: rtl/clock_gate_ctrl.sv
// Top-level clock-gating controller: one independent FSM per gated domain,
// global_enable fanned out to all of them.
// Optional feature macro: CLOCK_GATE_CTRL_STATS_EN exposes gated_cycles.
module clock_gate_ctrl
  import cgc_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               rst_n,
  clock_gate_ctrl_if.master  bus
);

  // One controller per domain; domains never share state.
  for (genvar i = 0; i < N_DOMAINS; i++) begin : g_dom
    cgc_state_e st;

    cgc_domain_fsm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_fsm (
      .clock         (clock),
      .rst_n         (rst_n),
      .global_enable (bus.global_enable),
      .force_on      (bus.force_on[i]),
      .busy          (bus.busy[i]),
      .wake_req      (bus.wake_req[i]),
      .quiesce_ack   (bus.quiesce_ack[i]),
      .quiesce_req   (bus.quiesce_req[i]),
      .gate_en       (bus.gate_en[i]),
      .domain_ready  (bus.domain_ready[i]),
`ifdef CLOCK_GATE_CTRL_STATS_EN
      .gated_cycles  (bus.gated_cycles[CGC_STAT_W*i +: CGC_STAT_W]),
`endif
      .domain_state  (st)
    );

    assign bus.domain_state[2*i +: 2] = st;
  end

endmodule
